// File: rtl/aesproject_nios2_mul_pkg.sv
// rtl/aesproject_nios2_mul_pkg.sv - shared mode encoding for the Nios II multiply pipe
package aesproject_nios2_mul_pkg;

    // Operation select carried alongside the operands
    typedef enum logic [1:0] {
        MUL    = 2'd0,  // low word of the product
        MULXSS = 2'd1,  // high word, signed x signed
        MULXSU = 2'd2,  // high word, signed src1 x unsigned src2
        MULXUU = 2'd3   // high word, unsigned x unsigned
    } mul_mode_e;

    localparam int MODE_W = 2;

endpackage

// File: rtl/aesproject_nios2_mul_pp.sv
// rtl/aesproject_nios2_mul_pp.sv - registered HALFxHALF unsigned partial-product multiplier
module aesproject_nios2_mul_pp #(
    parameter int HALF = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [HALF-1:0]   a,
    input  logic [HALF-1:0]   b,
    output logic [2*HALF-1:0] p_q
);

    logic [2*HALF-1:0] p_d;

    // Capture a new product when enabled, otherwise hold for the stalled pipe
    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};
        end
    end

    // Product register with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/aesproject_nios2_cpu_mul_pipe.sv
// rtl/aesproject_nios2_cpu_mul_pipe.sv - two-stage multiplier; AESPROJECT_MUL_PIPE_HI_EN enables high-word modes
module aesproject_nios2_cpu_mul_pipe
    import aesproject_nios2_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int HALF = WIDTH / 2;

    logic             ready_q, ready_d;
    logic             v1_q, v1_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] word;
    logic             stall;
    logic             accept;

    logic [WIDTH-1:0] ll_q, lh_q, hl_q;

    // ready_q stays low in reset so in_ready rises only on the first edge after release
    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = ready_q && !stall;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;

    aesproject_nios2_mul_pp #(.HALF(HALF)) u_pp_ll (
        .clk(clk), .reset_n(reset_n), .en(in_ready),
        .a(src1[HALF-1:0]), .b(src2[HALF-1:0]), .p_q(ll_q)
    );

    aesproject_nios2_mul_pp #(.HALF(HALF)) u_pp_lh (
        .clk(clk), .reset_n(reset_n), .en(in_ready),
        .a(src1[HALF-1:0]), .b(src2[WIDTH-1:HALF]), .p_q(lh_q)
    );

    aesproject_nios2_mul_pp #(.HALF(HALF)) u_pp_hl (
        .clk(clk), .reset_n(reset_n), .en(in_ready),
        .a(src1[WIDTH-1:HALF]), .b(src2[HALF-1:0]), .p_q(hl_q)
    );

`ifdef AESPROJECT_MUL_PIPE_HI_EN
    logic [WIDTH-1:0]   hh_q;
    logic [WIDTH-1:0]   src1_q, src1_d;
    logic [WIDTH-1:0]   src2_q, src2_d;
    mul_mode_e          mode_q, mode_d;
    logic [2*WIDTH-1:0] prod;

    aesproject_nios2_mul_pp #(.HALF(HALF)) u_pp_hh (
        .clk(clk), .reset_n(reset_n), .en(in_ready),
        .a(src1[WIDTH-1:HALF]), .b(src2[WIDTH-1:HALF]), .p_q(hh_q)
    );

    // Stage-1 side registers: mode and raw operands for the sign correction
    always_comb begin
        mode_d = mode_q;
        src1_d = src1_q;
        src2_d = src2_q;
        if (in_ready) begin
            mode_d = mul_mode_e'(mode);
            src1_d = src1;
            src2_d = src2;
        end
    end

    // Side registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= MUL;
            src1_q <= '0;
            src2_q <= '0;
        end else begin
            mode_q <= mode_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
        end
    end

    // Sum partial products, then subtract the two's-complement sign terms
    always_comb begin
        prod = {{WIDTH{1'b0}}, ll_q}
             + {{HALF{1'b0}}, lh_q, {HALF{1'b0}}}
             + {{HALF{1'b0}}, hl_q, {HALF{1'b0}}}
             + {hh_q, {WIDTH{1'b0}}};
        if (src1_q[WIDTH-1] && (mode_q == MULXSS || mode_q == MULXSU)) begin
            prod = prod - {src2_q, {WIDTH{1'b0}}};
        end
        if (src2_q[WIDTH-1] && mode_q == MULXSS) begin
            prod = prod - {src1_q, {WIDTH{1'b0}}};
        end
        word = (mode_q == MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end
`else
    logic unused_lo_only;

    // Only the low word exists in this build; mode and the upper cross-product halves are dropped
    assign unused_lo_only = ^{mode, lh_q[WIDTH-1:HALF], hl_q[WIDTH-1:HALF]};

    // Low word: ll plus the low halves of the cross products shifted into place
    always_comb begin
        word = ll_q
             + {lh_q[HALF-1:0], {HALF{1'b0}}}
             + {hl_q[HALF-1:0], {HALF{1'b0}}};
    end
`endif

    // Valid pipeline and result capture; flush wins over stall and new input
    always_comb begin
        ready_d     = 1'b1;
        v1_d        = v1_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        if (flush) begin
            v1_d        = 1'b0;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            v1_d        = accept;
            out_valid_d = v1_q;
        end
        if (!stall && v1_q) begin
            result_d = word;
        end
    end

    // Control and result registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            ready_q     <= ready_d;
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: doc/aesproject_nios2_cpu_mul_pipe.md
AESPROJECT_NIOS2_CPU_MUL_PIPE -- requirements
Module: aesproject_nios2_cpu_mul_pipe

Interface
REQ-001 Parameter WIDTH, 32, operand and result width; SHALL be even and in the range 16..64.
REQ-002 Parameter HALF, WIDTH/2, width of each partial-product operand; it is derived and SHALL NOT be overridden.
REQ-003 Port clk  input  1  single clock for all state.
REQ-004 Port reset_n  input  1  asynchronous active-low reset; assertion acts immediately, release is synchronous to clk.
REQ-005 Port flush  input  1  synchronous pipeline kill; clears all valids.
REQ-006 Port in_valid  input  1  operands and mode are presented.
REQ-007 Port in_ready  output  1  block accepts operands this cycle.
REQ-008 Port src1  input  WIDTH  multiplicand.
REQ-009 Port src2  input  WIDTH  multiplier.
REQ-010 Port mode  input  2  operation select: 0 MUL (low word), 1 MULXSS (high word, signed x signed), 2 MULXSU (high word, signed src1 x unsigned src2), 3 MULXUU (high word, unsigned x unsigned).
REQ-011 Port out_valid  output  1  result is valid.
REQ-012 Port out_ready  input  1  consumer accepts the result.
REQ-013 Port result  output  WIDTH  selected word of the 2*WIDTH product.

Function
REQ-014 Stage 1 SHALL register four unsigned HALFxHALF partial products: ll = lo1*lo2, lh = lo1*hi2, hl = hi1*lo2, hh = hi1*hi2.
REQ-015 Stage 1 SHALL also register mode, plus src1 and src2 wherever signed correction needs them.
REQ-016 Stage 2 SHALL form the 2*WIDTH unsigned product as ll + (lh<<HALF) + (hl<<HALF) + (hh<<WIDTH).
REQ-017 Stage 2 SHALL apply two's-complement correction: subtract src2<<WIDTH if src1 is negative and the mode is signed for src1; subtract src1<<WIDTH if src2 is negative and mode is 1.
REQ-018 Stage 2 SHALL register as result the low WIDTH bits for mode 0 and the high WIDTH bits for modes 1-3.
REQ-019 Latency SHALL be exactly 2 cycles from in_valid&&in_ready to out_valid when there is no backpressure; throughput is one operation per cycle.
REQ-020 Stall condition stall = out_valid && !out_ready; while stall is asserted, every pipeline register SHALL hold and in_ready SHALL be 0.
REQ-021 in_ready SHALL equal !stall, and SHALL NOT depend combinationally on in_valid.
REQ-022 result SHALL remain stable while out_valid && !out_ready.
REQ-023 A bubble in stage 1 SHALL propagate as out_valid=0; no operation SHALL be duplicated or dropped.
REQ-024 flush SHALL clear both stage valids on the next edge, overriding stall and any simultaneous in_valid; data registers need not clear.
REQ-025 Arithmetic SHALL be exact modulo 2^(2*WIDTH), with no saturation.

Reset
REQ-026 On reset_n low: stage valids = 0, out_valid = 0, result = 0, in_ready = 0.
REQ-027 in_ready SHALL go to 1 on the first clk edge after reset_n releases.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; no partial result SHALL appear after release.

Configuration
REQ-029 Macro AESPROJECT_MUL_PIPE_HI_EN defined: modes 1-3 SHALL be supported as specified, and the hh product plus correction logic SHALL be built.
REQ-030 Macro undefined: the hh product, correction logic and the mode register SHALL be omitted, every mode SHALL return the low word (MUL), and the port list SHALL be unchanged.

Structure
REQ-031 Shared package aesproject_nios2_mul_pkg SHALL hold the mode encoding constants (MUL, MULXSS, MULXSU, MULXUU) and the mode typedef.
REQ-032 Sub-module aesproject_nios2_mul_pp SHALL be one registered HALFxHALF unsigned multiplier with enable and async clear, instanced four times (three when AESPROJECT_MUL_PIPE_HI_EN is undefined).
REQ-033 No vendor megafunction SHALL be used; inference only.

Verification
REQ-034 WIDTH=32, HI_EN, src1=src2=0xFFFFFFFF, modes 0/1/2/3 back-to-back -> results 0x00000001, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE on four consecutive cycles, 2 cycles after the first accept.
REQ-035 src1=0x00010000, src2=0x00010000, mode 0 then mode 3 -> 0x00000000 then 0x00000001.
REQ-036 Three ops accepted, out_ready held 0 for 5 cycles -> in_ready=0 and result held at the first value; after release, all three results appear in order with none lost.
REQ-037 flush asserted with two ops in flight and in_valid=1 -> out_valid=0 for the next 2 cycles, and no result from any of those ops.
REQ-038 reset_n pulsed low between cycles mid-stream -> out_valid and result drop to 0 immediately; in_ready=1 one edge after release.
REQ-039 HI_EN undefined, src1=src2=0xFFFFFFFF, mode 3 -> result 0x00000001; random 10k ops in both configurations checked against a 2*WIDTH reference model at WIDTH 16/32/64.
